gates7_selftest_ctrl: RTL and testbench
=======================================

// Module: gates7_selftest_ctrl
// PURPOSE
//  Sequencer and self-test controller for the shared 7-gate logic unit
//  (and/or/not/nand/nor/xor/xnor). On start, it walks the unit through all
//  four {a,b} input vectors, waits a settle time, and compares the 7 results
//  against an internal golden model. It accumulates a per-gate error mask and
//  a per-vector fail map, then reports done/pass. It sits between system
//  control and the gate unit and owns the unit's a/b inputs.
// PARAMETERS
//  SETTLE  2  cycles waited after driving a vector before sampling f_in (0..15)
// PORTS
//  clk       in   1  clock, rising edge
//  rst       in   1  reset, asynchronous, active-high
//  start     in   1  run request; accepted only in IDLE
//  a_o       out  1  registered input a to gate unit
//  b_o       out  1  registered input b to gate unit
//  f_in      in   7  unit results: [6]and [5]or [4]not(~a) [3]nand [2]nor [1]xor [0]xnor
//  busy      out  1  high in DRIVE/SETTLE/CHECK/FINISH
//  done      out  1  one-cycle pulse in FINISH
//  pass      out  1  1 = last run had zero mismatches; held until next accepted start
//  err_mask  out  7  sticky OR of mismatching f_in bits over the run
//  fail_vec  out  4  bit i set = vector i ({a,b}=i) had any mismatch
// BEHAVIOUR
//  Reset (async, any state, mid-run included): state=IDLE; a_o=b_o=0; busy=done=pass=0;
//   err_mask=0; fail_vec=0; vector index=0; settle counter=0.
//  FSM: IDLE -> DRIVE -> SETTLE -> CHECK -> (DRIVE | FINISH) -> IDLE.
//  - IDLE: a_o=b_o=0. When start=1 at an edge: clear err_mask/fail_vec/pass, idx=0,
//    go to DRIVE. When start=0, remain in IDLE.
//  - DRIVE (1 cycle): a_o=idx[1], b_o=idx[0]; load counter=SETTLE. Go to SETTLE, or
//    go directly to CHECK if SETTLE=0.
//  - SETTLE (SETTLE cycles): decrement counter; go to CHECK when it reaches 1.
//  - CHECK (1 cycle): sample f_in; golden={a&b, a|b, ~a, ~(a&b), ~(a|b), a^b, ~(a^b)}
//    from a_o/b_o; mism=f_in^golden; err_mask|=mism; fail_vec[idx]|=|mism.
//    Go to DRIVE with idx+1 if idx<3; otherwise go to FINISH.
//  - FINISH (1 cycle): done=1; pass=(err_mask_next==0); a_o=b_o=0; go to IDLE.
//  Vector order 00,01,10,11. a/b held stable for SETTLE+2 cycles per vector.
//  Latency: if start is sampled at edge 0, done is high in cycle 4*(SETTLE+2)+1
//   (17 for SETTLE=2).
//  start during busy (including FINISH) is ignored with no queuing. start held high
//   starts a new run on the edge after the return to IDLE.
//  Results stay stable from FINISH until the next accepted start or reset.
//  X on f_in counts as a mismatch in simulation. The bench must not rely on this.
// TESTING
//  1 Golden gate model, SETTLE=2, 1-cycle start -> a/b = 00,01,10,11, each held 4
//    cycles; done pulses once at cycle 17; pass=1; err_mask=0; fail_vec=0.
//  2 xor output stuck-at-0 -> err_mask=7'b0000010, fail_vec=4'b0110, pass=0.
//  3 not output wired to a (not inverted) -> err_mask=7'b0010000, fail_vec=4'b1111,
//    pass=0.
//  4 Second start pulse mid-run, then start held high -> no effect mid-run; the next
//    run begins the cycle after IDLE; the prior failing err_mask is cleared on accept.
//  5 rst pulsed during vector 2 -> same cycle: busy=0, a_o=b_o=0, err_mask=0, pass=0;
//    a fresh start completes a full run with pass=1.
//  6 SETTLE=0 build -> 2 cycles per vector; done at cycle 9; results match test 1.

Source files
------------

// File: rtl/gates7_selftest_ctrl_if.sv
// Bundle between the self-test controller, system control and the shared 7-gate unit.
// The master drives start and returns the unit results; the slave is the controller.
interface gates7_selftest_ctrl_if;
  logic       start;
  logic       a_o;
  logic       b_o;
  logic [6:0] f_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_mask;
  logic [3:0] fail_vec;

  modport master (
    output start,
    output f_in,
    input  a_o,
    input  b_o,
    input  busy,
    input  done,
    input  pass,
    input  err_mask,
    input  fail_vec
  );

  modport slave (
    input  start,
    input  f_in,
    output a_o,
    output b_o,
    output busy,
    output done,
    output pass,
    output err_mask,
    output fail_vec
  );
endinterface

// File: rtl/gates7_selftest_ctrl.sv
// Self-test sequencer for the shared 7-gate unit: walks {a,b} through 00..11,
// waits SETTLE cycles per vector and compares the unit results against a golden model.
module gates7_selftest_ctrl #(
  parameter int SETTLE = 2
) (
  input logic                    clk,
  input logic                    rst,
  gates7_selftest_ctrl_if.slave  bus
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       a_r;
  logic       b_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [6:0] err_r;
  logic [3:0] fail_r;

  logic [6:0] golden;
  logic [6:0] mism;
  logic [6:0] err_next;
  logic [1:0] idx_next;

  // Golden results are derived from the registered a/b the unit is actually seeing.
  always_comb begin
    golden   = {a_r & b_r, a_r | b_r, ~a_r, ~(a_r & b_r), ~(a_r | b_r), a_r ^ b_r, ~(a_r ^ b_r)};
    mism     = bus.f_in ^ golden;
    err_next = err_r | mism;
    idx_next = idx + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      cnt    <= 4'd0;
      a_r    <= 1'b0;
      b_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      err_r  <= 7'd0;
      fail_r <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          a_r    <= 1'b0;
          b_r    <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            state  <= S_DRIVE;
            idx    <= 2'd0;
            busy_r <= 1'b1;
            pass_r <= 1'b0;
            err_r  <= 7'd0;
            fail_r <= 4'd0;
          end
        end
        S_DRIVE: begin
          cnt <= SETTLE_CNT;
          if (SETTLE_CNT == 4'd0) begin
            state <= S_CHECK;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_r  <= err_next;
          fail_r <= fail_r | ({3'b000, |mism} << idx);
          if (idx != 2'd3) begin
            // Next vector is presented on the same edge so DRIVE already sees it.
            idx   <= idx_next;
            a_r   <= idx_next[1];
            b_r   <= idx_next[0];
            state <= S_DRIVE;
          end else begin
            a_r    <= 1'b0;
            b_r    <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_next == 7'd0);
            state  <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          a_r    <= 1'b0;
          b_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_o      = a_r;
  assign bus.b_o      = b_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.err_mask = err_r;
  assign bus.fail_vec = fail_r;

endmodule

// File: tb/tb_gates7_selftest_ctrl.sv
// Bench for gates7_selftest_ctrl: a SETTLE=2 and a SETTLE=0 instance, each driving
// a fault-injectable gate unit, checked against a truth-table reference model.
module tb_gates7_selftest_ctrl;

  logic clk;
  logic rst;
  logic [6:0] s0;
  logic [6:0] s1;
  logic [6:0] inv;
  int errors;
  int checks;

  gates7_selftest_ctrl_if bus0 ();
  gates7_selftest_ctrl_if bus1 ();

  gates7_selftest_ctrl #(.SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gates7_selftest_ctrl #(.SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Faulty unit: invert, then stuck-at-0, then stuck-at-1, applied to every vector.
  assign bus0.f_in = ((({bus0.a_o & bus0.b_o, bus0.a_o | bus0.b_o, ~bus0.a_o, ~(bus0.a_o & bus0.b_o),
                         ~(bus0.a_o | bus0.b_o), bus0.a_o ^ bus0.b_o, ~(bus0.a_o ^ bus0.b_o)}) ^ inv) & ~s0) | s1;
  assign bus1.f_in = ((({bus1.a_o & bus1.b_o, bus1.a_o | bus1.b_o, ~bus1.a_o, ~(bus1.a_o & bus1.b_o),
                         ~(bus1.a_o | bus1.b_o), bus1.a_o ^ bus1.b_o, ~(bus1.a_o ^ bus1.b_o)}) ^ inv) & ~s0) | s1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] inv;
    logic [6:0] exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  vec_t table_v[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] f_s0, input logic [6:0] f_s1, input logic [6:0] f_inv);
    s0  = f_s0;
    s1  = f_s1;
    inv = f_inv;
  endtask

  task automatic setStart(input int which, input logic v);
    if (which == 0) bus0.start = v;
    else            bus1.start = v;
  endtask

  task automatic sample(input int which, output logic a, output logic b, output logic busy,
                        output logic done, output logic pass, output logic [6:0] err, output logic [3:0] fail);
    if (which == 0) begin
      a = bus0.a_o; b = bus0.b_o; busy = bus0.busy; done = bus0.done;
      pass = bus0.pass; err = bus0.err_mask; fail = bus0.fail_vec;
    end else begin
      a = bus1.a_o; b = bus1.b_o; busy = bus1.busy; done = bus1.done;
      pass = bus1.pass; err = bus1.err_mask; fail = bus1.fail_vec;
    end
  endtask

  // Truth table of the seven gates built from integer arithmetic, bit 6 = and.
  function automatic logic [6:0] truthRow(input int v);
    int a;
    int b;
    int g[7];
    logic [6:0] r;
    a = v / 2;
    b = v % 2;
    g = '{a * b, a + b - a * b, 1 - a, 1 - a * b, 1 - (a + b - a * b), (a + b) % 2, 1 - (a + b) % 2};
    for (int i = 0; i < 7; i++) r[6-i] = g[i][0];
    return r;
  endfunction

  task automatic refModel(output logic [6:0] err, output logic [3:0] fail, output logic pass);
    logic [6:0] good;
    logic [6:0] f;
    err  = '0;
    fail = '0;
    for (int v = 0; v < 4; v++) begin
      good = truthRow(v);
      f    = ((good ^ inv) & ~s0) | s1;
      err  = err | (f ^ good);
      if ((f ^ good) != 7'd0) fail[v] = 1'b1;
    end
    pass = (err == 7'd0);
  endtask

  // One full run from an idle cycle: checks the a/b sequence, busy/done timing and results.
  task automatic runCheck(input int which, input logic [6:0] exp_err, input logic [3:0] exp_fail,
                          input logic exp_pass, input string tag);
    int per;
    int total;
    int bad;
    int first_bad;
    int vec;
    logic a, b, busy, done, pass;
    logic [6:0] err;
    logic [3:0] fail;
    per       = (which == 0) ? 4 : 2;
    total     = 4 * per + 1;
    bad       = 0;
    first_bad = 0;
    setStart(which, 1'b1);
    @(posedge clk); #1;
    setStart(which, 1'b0);
    for (int k = 1; k <= total + 1; k++) begin
      sample(which, a, b, busy, done, pass, err, fail);
      vec = (k <= 4 * per) ? (k - 1) / per : 0;
      if (a !== vec[1] || b !== vec[0] || busy !== (k <= total) || done !== (k == total)) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      @(posedge clk); #1;
    end
    if (bad != 0) $display("[TB] %s: first bad cycle %0d", tag, first_bad);
    checkOutput({tag, " seq"}, bad, 0);
    sample(which, a, b, busy, done, pass, err, fail);
    checkOutput({tag, " err_mask"}, {25'd0, err}, {25'd0, exp_err});
    checkOutput({tag, " fail_vec"}, {28'd0, fail}, {28'd0, exp_fail});
    checkOutput({tag, " pass"}, {31'd0, pass}, {31'd0, exp_pass});
  endtask

  initial begin
    logic a, b, busy, done, pass;
    logic [6:0] err, m_err;
    logic [3:0] fail, m_fail;
    logic m_pass;
    int done_cnt;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    applyStimulus(7'd0, 7'd0, 7'd0);

    table_v[0] = '{7'd0,         7'd0,         7'd0,         7'd0,         4'b0000, 1'b1};
    table_v[1] = '{7'b0000010,   7'd0,         7'd0,         7'b0000010,   4'b0110, 1'b0};
    table_v[2] = '{7'd0,         7'd0,         7'b0010000,   7'b0010000,   4'b1111, 1'b0};
    table_v[3] = '{7'd0,         7'b1000000,   7'd0,         7'b1000000,   4'b0111, 1'b0};
    table_v[4] = '{7'b0000001,   7'd0,         7'd0,         7'b0000001,   4'b1001, 1'b0};
    table_v[5] = '{7'd0,         7'b0000100,   7'd0,         7'b0000100,   4'b1110, 1'b0};
    table_v[6] = '{7'd0,         7'd0,         7'b0100000,   7'b0100000,   4'b1111, 1'b0};

    #12;
    for (int w = 0; w < 2; w++) begin
      sample(w, a, b, busy, done, pass, err, fail);
      checkOutput($sformatf("reset state dut%0d", w), {16'd0, a, b, busy, done, pass, err, fail}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      for (int w = 0; w < 2; w++) begin
        applyStimulus(table_v[i].s0, table_v[i].s1, table_v[i].inv);
        runCheck(w, table_v[i].exp_err, table_v[i].exp_fail, table_v[i].exp_pass,
                 $sformatf("table%0d dut%0d", i, w));
      end
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(7'($urandom & $urandom & $urandom), 7'($urandom & $urandom & $urandom),
                    7'($urandom & $urandom & $urandom));
      refModel(m_err, m_fail, m_pass);
      runCheck(i % 2, m_err, m_fail, m_pass, $sformatf("random%0d", i));
    end

    // Start during a run is ignored; start held high re-launches right after IDLE.
    applyStimulus(7'b0000010, 7'd0, 7'd0);
    runCheck(0, 7'b0000010, 4'b0110, 1'b0, "pre-restart");
    applyStimulus(7'd0, 7'd0, 7'd0);
    done_cnt = 0;
    setStart(0, 1'b1);
    @(posedge clk); #1;
    setStart(0, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      sample(0, a, b, busy, done, pass, err, fail);
      if (done === 1'b1) done_cnt++;
      if (k == 1)  checkOutput("restart cleared", {24'd0, err, pass}, 32'd0);
      if (k == 17) checkOutput("restart done1", {16'd0, done, pass, err}, {16'd0, 1'b1, 1'b1, 7'd0});
      if (k == 18) checkOutput("restart idle", {31'd0, busy}, 32'd0);
      if (k == 19) checkOutput("restart relaunch", {30'd0, busy, pass}, {30'd0, 2'b10});
      if (k == 35) checkOutput("restart done2", {12'd0, done, pass, err, fail},
                               {12'd0, 1'b1, 1'b0, 7'b1000000, 4'b0111});
      if (k == 18) applyStimulus(7'd0, 7'b1000000, 7'd0);
      setStart(0, (k >= 5 && k <= 19));
      @(posedge clk); #1;
    end
    checkOutput("restart done count", done_cnt, 2);

    // Asynchronous reset in the middle of vector 2.
    applyStimulus(7'b0000010, 7'd0, 7'd0);
    setStart(0, 1'b1);
    @(posedge clk); #1;
    setStart(0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    sample(0, a, b, busy, done, pass, err, fail);
    checkOutput("mid-run before rst", {23'd0, a, b, busy, err}, {23'd0, 1'b1, 1'b0, 1'b1, 7'b0000010});
    #2 rst = 1'b1;
    #1;
    sample(0, a, b, busy, done, pass, err, fail);
    checkOutput("rst mid-run", {16'd0, a, b, busy, done, pass, err, fail}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(7'd0, 7'd0, 7'd0);
    runCheck(0, 7'd0, 4'd0, 1'b1, "after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
